sram_march_bist_ctrl: RTL and testbench
=======================================

Name: sram_march_bist_ctrl

Overview:
- Built-in self-test controller for the single-port IHP SG13 SRAM macros with byte-mask and BIST port, for example the 8192x32 c4 variant.
- Runs a March C- sequence through the macro's dedicated A_BIST_* port and checks A_DOUT against expected data.
- Reports pass/fail, the first failing address and march element, and a saturating mismatch count.
- Sits beside each macro instance and is triggered by the SoC test/debug register block.

Parameters:
- P_ADDR_WIDTH, 13, macro address width; N = 2^P_ADDR_WIDTH words.
- P_DATA_WIDTH, 32, macro data width.
- P_STOP_ON_FAIL, 0, 1 = terminate the run after the first mismatch.
- P_CNT_WIDTH, 16, width of the saturating mismatch counter.

Ports:
- A_CLK  in  1  clock; the integration also routes it to the macro's A_BIST_CLK.
- A_RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle run request.
- BUSY  out  1  run in progress.
- DONE  out  1  run finished; held until the next accepted START or reset.
- FAIL  out  1  sticky, at least one mismatch in the current/last run.
- FAIL_ADDR  out  P_ADDR_WIDTH  address of the first mismatch.
- FAIL_ELEM  out  3  march element (0-5) of the first mismatch.
- FAIL_CNT  out  P_CNT_WIDTH  mismatch count, saturating at all-ones.
- A_BIST_EN  out  1  selects the BIST port on the macro.
- A_BIST_MEN, A_BIST_WEN, A_BIST_REN  out  1 each  macro BIST controls.
- A_BIST_ADDR  out  P_ADDR_WIDTH  macro BIST address.
- A_BIST_DIN  out  P_DATA_WIDTH  macro BIST write data.
- A_BIST_BM  out  P_DATA_WIDTH  byte/bit mask; constant all-ones.
- A_DOUT  in  P_DATA_WIDTH  macro read data.

Behaviour:
- One clock A_CLK. A_RST is synchronous and active-high.
- Reset values: all outputs 0 except A_BIST_BM = all-ones; state IDLE.
  - Reset mid-run aborts at the next edge and drops A_BIST_EN, returning the macro to the functional port.
  - Memory contents after an aborted run are undefined.
- States: IDLE, M0..M5, CHECK, FIN.
- IDLE:
  - START=1 at edge e0 → M0 with addr=0.
  - At e0, clear FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_CNT and DONE; set BUSY=1 and A_BIST_EN=1.
  - START while BUSY is ignored.
- March C- elements (0 = all-zeros, 1 = all-ones data):
  - M0 up (w0).
  - M1 up (r0, w1).
  - M2 up (r1, w0).
  - M3 down (r0, w1).
  - M4 down (r1, w0).
  - M5 up (r0).
  - "up" runs 0→N-1; "down" runs N-1→0.
- Access timing:
  - Exactly one macro access per cycle; MEN=1 throughout M0..M5.
  - Two-op elements alternate read then write at the same address; the address steps after the write.
  - Single-op elements step the address every cycle.
  - Wrap from a terminal address moves to the next element's start address in the same edge; no idle cycles between elements.
  - A_BIST_WEN/REN are one-hot during access cycles; DIN = expected write pattern.
- Read check pipeline:
  - A read presented in cycle t is sampled by the macro at edge t+1.
  - Controller registers the expected data, address and element at edge t+1 and compares A_DOUT during cycle t+1, committing the result at edge t+2.
  - Mismatch is a full-word inequality.
  - First mismatch of a run latches FAIL_ADDR and FAIL_ELEM.
  - Every mismatch increments FAIL_CNT, which saturates.
- Run length:
  - Access cycles = 10N, then one CHECK cycle (MEN=0) to commit the last compare.
  - Then FIN: BUSY=0, DONE=1, A_BIST_EN=0, return to IDLE.
  - BUSY is high for 10N+1 cycles after e0.
- P_STOP_ON_FAIL=1:
  - On a committed mismatch, go to FIN at that edge; the access in flight is discarded.
  - DONE=1, FAIL=1.
- Outside M0..M5: MEN, WEN, REN = 0; ADDR and DIN hold 0.
- A_RST has priority over START in the same cycle.

Test Plan:
- Fault-free memory model, P_ADDR_WIDTH=4 (N=16): pulse START → BUSY high exactly 161 cycles; DONE=1, FAIL=0, FAIL_CNT=0; exactly 160 MEN cycles with 80 writes and 80 reads.
- Stuck-at-0 on bit 5 of word 7, N=16 → FAIL=1, FAIL_ELEM=2, FAIL_ADDR=7, FAIL_CNT=2 (M2 and M4 reads).
- Same fault with P_STOP_ON_FAIL=1 → DONE asserted 2 cycles after the M2 read at address 7 is presented; FAIL_CNT=1; no further MEN cycles.
- Address order check: in M3 the first A_BIST_ADDR is 15 and the last is 0; M5 runs 0..15; every read is immediately followed by a write to the same address.
- START pulsed again at cycle 50 of a run → ignored; run completes at 161. A new START after DONE clears FAIL and FAIL_CNT and restarts.
- A_RST asserted at cycle 70 → at the next edge BUSY=0, DONE=0, A_BIST_EN=0, MEN=0. A subsequent START runs clean with FAIL=0.

Source files
------------

// File: rtl/sram_march_bist_ctrl_if.sv
// Bundle between the March C- BIST controller and its SoC side: the
// test/debug register block (START and the status outputs) and the SRAM
// macro's dedicated BIST port (A_BIST_* and A_DOUT).
//
// Handshake: START is a single-cycle request with no ready.
// - It is accepted only while the controller is idle.
// - Acceptance shows up as BUSY=1 from the next cycle.
// - DONE=1 marks completion and stays up until the next accepted START.
//
// modport master : the controller (drives status and the BIST port).
// modport slave  : the register block / macro side.
// dbg_state      : the controller's FSM state, exported for checkers.
interface sram_march_bist_ctrl_if #(
    parameter int P_ADDR_WIDTH = 13,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_CNT_WIDTH  = 16
);
    logic                    START;
    logic                    BUSY;
    logic                    DONE;
    logic                    FAIL;
    logic [P_ADDR_WIDTH-1:0] FAIL_ADDR;
    logic [2:0]              FAIL_ELEM;
    logic [P_CNT_WIDTH-1:0]  FAIL_CNT;
    logic                    A_BIST_EN;
    logic                    A_BIST_MEN;
    logic                    A_BIST_WEN;
    logic                    A_BIST_REN;
    logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR;
    logic [P_DATA_WIDTH-1:0] A_BIST_DIN;
    logic [P_DATA_WIDTH-1:0] A_BIST_BM;
    logic [P_DATA_WIDTH-1:0] A_DOUT;
    logic [3:0]              dbg_state;

    modport master (
        input  START, A_DOUT,
        output BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_CNT,
        output A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
        output A_BIST_ADDR, A_BIST_DIN, A_BIST_BM, dbg_state
    );

    modport slave (
        output START, A_DOUT,
        input  BUSY, DONE, FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_CNT,
        input  A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
        input  A_BIST_ADDR, A_BIST_DIN, A_BIST_BM, dbg_state
    );
endinterface

// File: rtl/sram_march_bist_ctrl.sv
// March C- built-in self-test controller for a single-port SRAM macro with
// a dedicated BIST port.
//
// Element sequence (0 = all-zeros data, 1 = all-ones data):
//   M0 up (w0), M1 up (r0,w1), M2 up (r1,w0),
//   M3 down (r0,w1), M4 down (r1,w0), M5 up (r0).
// A run is 10N access cycles, followed by one CHECK cycle and one FIN cycle.
//
// Ports:
//   A_CLK  : clock (also the macro's BIST clock at integration level).
//   A_RST  : synchronous, active-high reset.
//   bus    : master side of sram_march_bist_ctrl_if, carrying
//            - START / BUSY / DONE,
//            - FAIL / FAIL_ADDR / FAIL_ELEM / FAIL_CNT,
//            - the A_BIST_* macro controls and A_DOUT read data.
//
// Read check: a read presented in cycle t is sampled by the macro at edge
// t+1. The expected word, address and element are registered at that same
// edge. A_DOUT is compared during cycle t+1 and the result committed at
// edge t+2.
module sram_march_bist_ctrl #(
    parameter int P_ADDR_WIDTH   = 13,
    parameter int P_DATA_WIDTH   = 32,
    parameter int P_STOP_ON_FAIL = 0,
    parameter int P_CNT_WIDTH    = 16
) (
    input  logic                     A_CLK,
    input  logic                     A_RST,
    sram_march_bist_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_M0    = 4'd1,
        S_M1    = 4'd2,
        S_M2    = 4'd3,
        S_M3    = 4'd4,
        S_M4    = 4'd5,
        S_M5    = 4'd6,
        S_CHECK = 4'd7,
        S_FIN   = 4'd8
    } state_t;

    localparam logic [P_ADDR_WIDTH-1:0] ADDR_ZERO = '0;
    localparam logic [P_ADDR_WIDTH-1:0] ADDR_LAST = '1;

    state_t                  state_q, state_d, nxt_state;
    logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                    phase_q, phase_d;      // 0 = read op, 1 = write op
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    fail_q, fail_d;
    logic [P_ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]              fail_elem_q, fail_elem_d;
    logic [P_CNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;
    logic                    bist_en_q, bist_en_d;
    logic                    men_q, men_d;
    logic                    wen_q, wen_d;
    logic                    ren_q, ren_d;
    logic [P_ADDR_WIDTH-1:0] baddr_q, baddr_d;
    logic [P_DATA_WIDTH-1:0] din_q, din_d;
    logic                    chk_vld_q, chk_vld_d;
    logic [P_DATA_WIDTH-1:0] chk_exp_q, chk_exp_d;
    logic [P_ADDR_WIDTH-1:0] chk_addr_q, chk_addr_d;
    logic [2:0]              chk_elem_q, chk_elem_d;
    logic                    mism;

    function automatic logic is_access(input state_t s);
        return (s == S_M0) || (s == S_M1) || (s == S_M2) ||
               (s == S_M3) || (s == S_M4) || (s == S_M5);
    endfunction

    function automatic logic two_op(input state_t s);
        return (s == S_M1) || (s == S_M2) || (s == S_M3) || (s == S_M4);
    endfunction

    function automatic logic is_down(input state_t s);
        return (s == S_M3) || (s == S_M4);
    endfunction

    // Data written by an element: all-ones for M1/M3, zeros otherwise.
    function automatic logic wr_ones(input state_t s);
        return (s == S_M1) || (s == S_M3);
    endfunction

    // Data expected on reads: all-ones for M2/M4, zeros otherwise.
    function automatic logic rd_ones(input state_t s);
        return (s == S_M2) || (s == S_M4);
    endfunction

    function automatic logic [2:0] elem_of(input state_t s);
        case (s)
            S_M1:    return 3'd1;
            S_M2:    return 3'd2;
            S_M3:    return 3'd3;
            S_M4:    return 3'd4;
            S_M5:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic state_t next_elem(input state_t s);
        case (s)
            S_M0:    return S_M1;
            S_M1:    return S_M2;
            S_M2:    return S_M3;
            S_M3:    return S_M4;
            S_M4:    return S_M5;
            default: return S_CHECK;
        endcase
    endfunction

    assign mism = chk_vld_q && (bus.A_DOUT != chk_exp_q);

    always_comb begin
        state_d     = state_q;
        nxt_state   = S_IDLE;
        addr_d      = addr_q;
        phase_d     = phase_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_cnt_d  = fail_cnt_q;

        // Capture the read presented this cycle for comparison next cycle.
        chk_vld_d  = ren_q;
        chk_exp_d  = {P_DATA_WIDTH{rd_ones(state_q)}};
        chk_addr_d = addr_q;
        chk_elem_d = elem_of(state_q);

        if (mism) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = chk_addr_q;
                fail_elem_d = chk_elem_q;
            end
            if (fail_cnt_q != {P_CNT_WIDTH{1'b1}}) begin
                fail_cnt_d = fail_cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    state_d     = S_M0;
                    addr_d      = ADDR_ZERO;
                    phase_d     = 1'b0;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = 3'd0;
                    fail_cnt_d  = '0;
                    chk_vld_d   = 1'b0;
                end
            end
            S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
                if (two_op(state_q) && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    // Terminal address: jump straight to the next element's
                    // start so elements run back to back.
                    if (addr_q == (is_down(state_q) ? ADDR_ZERO : ADDR_LAST)) begin
                        nxt_state = next_elem(state_q);
                        state_d   = nxt_state;
                        addr_d    = is_down(nxt_state) ? ADDR_LAST : ADDR_ZERO;
                    end else if (is_down(state_q)) begin
                        addr_d = addr_q - 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_CHECK: state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Early termination drops whatever access is still in flight.
        if ((P_STOP_ON_FAIL != 0) && mism) begin
            state_d   = S_FIN;
            addr_d    = ADDR_ZERO;
            phase_d   = 1'b0;
            chk_vld_d = 1'b0;
        end

        // Outputs are registered, decoded from the next state.
        busy_d    = is_access(state_d) || (state_d == S_CHECK);
        if (state_d == S_FIN) begin
            done_d = 1'b1;
        end
        bist_en_d = busy_d;
        men_d     = is_access(state_d);
        wen_d     = men_d && ((state_d == S_M0) || (two_op(state_d) && phase_d));
        ren_d     = men_d && !wen_d;
        baddr_d   = men_d ? addr_d : '0;
        din_d     = men_d ? {P_DATA_WIDTH{wr_ones(state_d)}} : '0;
    end

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
            fail_cnt_q  <= '0;
            bist_en_q   <= 1'b0;
            men_q       <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            baddr_q     <= '0;
            din_q       <= '0;
            chk_vld_q   <= 1'b0;
            chk_exp_q   <= '0;
            chk_addr_q  <= '0;
            chk_elem_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_cnt_q  <= fail_cnt_d;
            bist_en_q   <= bist_en_d;
            men_q       <= men_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            baddr_q     <= baddr_d;
            din_q       <= din_d;
            chk_vld_q   <= chk_vld_d;
            chk_exp_q   <= chk_exp_d;
            chk_addr_q  <= chk_addr_d;
            chk_elem_q  <= chk_elem_d;
        end
    end

    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.FAIL        = fail_q;
    assign bus.FAIL_ADDR   = fail_addr_q;
    assign bus.FAIL_ELEM   = fail_elem_q;
    assign bus.FAIL_CNT    = fail_cnt_q;
    assign bus.A_BIST_EN   = bist_en_q;
    assign bus.A_BIST_MEN  = men_q;
    assign bus.A_BIST_WEN  = wen_q;
    assign bus.A_BIST_REN  = ren_q;
    assign bus.A_BIST_ADDR = baddr_q;
    assign bus.A_BIST_DIN  = din_q;
    assign bus.A_BIST_BM   = {P_DATA_WIDTH{1'b1}};
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
module tb_sram_march_bist_ctrl;
    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int CW   = 16;
    localparam int N    = 16;
    localparam int SB_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start_a, start_b;
    logic fault_a, fault_b;
    logic sel_b;
    int   n_total = 0;
    int   n_bad   = 0;

    sram_march_bist_ctrl_if #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_CNT_WIDTH(CW)) if_a ();
    sram_march_bist_ctrl_if #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_CNT_WIDTH(CW)) if_b ();

    sram_march_bist_ctrl #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW),
                           .P_STOP_ON_FAIL(0), .P_CNT_WIDTH(CW))
        dut_a (.A_CLK(clk), .A_RST(rst), .bus(if_a));
    sram_march_bist_ctrl #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW),
                           .P_STOP_ON_FAIL(1), .P_CNT_WIDTH(CW))
        dut_b (.A_CLK(clk), .A_RST(rst), .bus(if_b));

    assign if_a.START = start_a;
    assign if_b.START = start_b;

    // ---------------- SRAM models (optional stuck-at-0, bit 5 of word 7) ----------------
    logic [DW-1:0] mem_a [N];
    logic [DW-1:0] mem_b [N];
    logic [DW-1:0] dout_a, dout_b;
    assign if_a.A_DOUT = dout_a;
    assign if_b.A_DOUT = dout_b;

    always @(posedge clk) begin
        if (if_a.A_BIST_EN && if_a.A_BIST_MEN) begin
            if (if_a.A_BIST_WEN) mem_a[if_a.A_BIST_ADDR] <= if_a.A_BIST_DIN & if_a.A_BIST_BM;
            if (if_a.A_BIST_REN)
                dout_a <= mem_a[if_a.A_BIST_ADDR] &
                          ~((fault_a && if_a.A_BIST_ADDR == 4'd7) ? 32'h20 : 32'h0);
        end
        if (if_b.A_BIST_EN && if_b.A_BIST_MEN) begin
            if (if_b.A_BIST_WEN) mem_b[if_b.A_BIST_ADDR] <= if_b.A_BIST_DIN & if_b.A_BIST_BM;
            if (if_b.A_BIST_REN)
                dout_b <= mem_b[if_b.A_BIST_ADDR] &
                          ~((fault_b && if_b.A_BIST_ADDR == 4'd7) ? 32'h20 : 32'h0);
        end
    end

    // Monitored DUT, selected per run.
    wire          mon_busy = sel_b ? if_b.BUSY       : if_a.BUSY;
    wire          mon_done = sel_b ? if_b.DONE       : if_a.DONE;
    wire          mon_men  = sel_b ? if_b.A_BIST_MEN : if_a.A_BIST_MEN;
    wire          mon_wen  = sel_b ? if_b.A_BIST_WEN : if_a.A_BIST_WEN;
    wire          mon_ren  = sel_b ? if_b.A_BIST_REN : if_a.A_BIST_REN;
    wire [AW-1:0] mon_addr = sel_b ? if_b.A_BIST_ADDR : if_a.A_BIST_ADDR;
    wire [DW-1:0] mon_din  = sel_b ? if_b.A_BIST_DIN : if_a.A_BIST_DIN;

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard: expected access sequence ----------------
    // Entry = {wen, ren, addr, din_all_ones, din_all_zeros}; din bits are 0 for reads.
    logic [SB_W-1:0] exp_q[$];
    logic            sb_en;

    task automatic push_rd(input int a);
        logic [AW-1:0] av;
        av = AW'(a);
        exp_q.push_back({1'b0, 1'b1, av, 2'b00});
    endtask

    task automatic push_wr(input int a, input bit ones);
        logic [AW-1:0] av;
        av = AW'(a);
        exp_q.push_back({1'b1, 1'b0, av, ones, ~ones});
    endtask

    task automatic build_exp();
        int a;
        exp_q.delete();
        for (int el = 0; el < 6; el++) begin
            for (int i = 0; i < N; i++) begin
                a = (el == 3 || el == 4) ? (N - 1 - i) : i;
                case (el)
                    0: push_wr(a, 1'b0);
                    1: begin push_rd(a); push_wr(a, 1'b1); end
                    2: begin push_rd(a); push_wr(a, 1'b0); end
                    3: begin push_rd(a); push_wr(a, 1'b1); end
                    4: begin push_rd(a); push_wr(a, 1'b0); end
                    default: push_rd(a);
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        logic [SB_W-1:0] obs;
        logic [SB_W-1:0] e;
        if (sb_en && mon_men) begin
            obs = {mon_wen, mon_ren, mon_addr,
                   mon_wen && (mon_din == {DW{1'b1}}),
                   mon_wen && (mon_din == {DW{1'b0}})};
            if (exp_q.size() == 0) begin
                check_val("sb_extra_access", 64'(obs), 64'hff);
            end else begin
                e = exp_q.pop_front();
                check_val("sb_access", 64'(obs), 64'(e));
            end
        end
    end

    // ---------------- driver: one run with measurement ----------------
    int busy_n, men_n, wr_n, rd_n, done_cyc, rd7_cyc;
    logic fail_at1;
    logic [CW-1:0] cnt_at1;

    task automatic run(input bit use_b, input int again_at, input int rst_at);
        int rd7_n;
        rd7_n = 0;
        sel_b = use_b;
        busy_n = 0; men_n = 0; wr_n = 0; rd_n = 0; done_cyc = 0; rd7_cyc = 0;
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (cyc == 1) begin
                fail_at1 = use_b ? if_b.FAIL : if_a.FAIL;
                cnt_at1  = use_b ? if_b.FAIL_CNT : if_a.FAIL_CNT;
            end
            if (mon_done) begin
                done_cyc = cyc;
                break;
            end
            if (mon_busy) busy_n++;
            if (mon_men) men_n++;
            if (mon_men && mon_wen) wr_n++;
            if (mon_men && mon_ren) rd_n++;
            if (mon_men && mon_ren && mon_addr == 4'd7) begin
                rd7_n++;
                if (rd7_n == 2) rd7_cyc = cyc;
            end
            if (use_b) start_b = (cyc == again_at); else start_a = (cyc == again_at);
            if (cyc == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // ---------------- sequence ----------------
    initial begin
        int men_after;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        fault_a = 1'b0; fault_b = 1'b0; sel_b = 1'b0; sb_en = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy",      64'(if_a.BUSY), 0);
        check_val("rst_done",      64'(if_a.DONE), 0);
        check_val("rst_fail",      64'(if_a.FAIL), 0);
        check_val("rst_cnt",       64'(if_a.FAIL_CNT), 0);
        check_val("rst_fail_addr", 64'(if_a.FAIL_ADDR), 0);
        check_val("rst_fail_elem", 64'(if_a.FAIL_ELEM), 0);
        check_val("rst_en",        64'(if_a.A_BIST_EN), 0);
        check_val("rst_men",       64'({if_a.A_BIST_MEN, if_a.A_BIST_WEN, if_a.A_BIST_REN}), 0);
        check_val("rst_addr",      64'(if_a.A_BIST_ADDR), 0);
        check_val("rst_din",       64'(if_a.A_BIST_DIN), 0);
        check_val("rst_bm",        64'(if_a.A_BIST_BM), 64'hffff_ffff);
        check_val("rst_b_busy",    64'({if_b.BUSY, if_b.DONE, if_b.A_BIST_EN}), 0);
        rst = 1'b0;

        // Clean run with full access-sequence scoreboard.
        build_exp();
        sb_en = 1'b1;
        run(1'b0, 0, 0);
        sb_en = 1'b0;
        check_val("clean_sb_left",  64'(exp_q.size()), 0);
        check_val("clean_busy_n",   64'(busy_n), 161);
        check_val("clean_done_cyc", 64'(done_cyc), 162);
        check_val("clean_men_n",    64'(men_n), 160);
        check_val("clean_wr_n",     64'(wr_n), 80);
        check_val("clean_rd_n",     64'(rd_n), 80);
        check_val("clean_fail",     64'(if_a.FAIL), 0);
        check_val("clean_cnt",      64'(if_a.FAIL_CNT), 0);
        check_val("clean_fin_ctl",  64'({if_a.BUSY, if_a.A_BIST_EN, if_a.A_BIST_MEN}), 0);
        check_val("clean_fin_bus",  64'({if_a.A_BIST_ADDR, if_a.A_BIST_DIN}), 0);
        @(negedge clk);
        check_val("clean_done_hold", 64'(if_a.DONE), 1);

        // Stuck-at-0 at word 7 bit 5, run to completion.
        fault_a = 1'b1;
        run(1'b0, 0, 0);
        check_val("sa0_done_cyc", 64'(done_cyc), 162);
        check_val("sa0_busy_n",   64'(busy_n), 161);
        check_val("sa0_fail",     64'(if_a.FAIL), 1);
        check_val("sa0_elem",     64'(if_a.FAIL_ELEM), 2);
        check_val("sa0_addr",     64'(if_a.FAIL_ADDR), 7);
        check_val("sa0_cnt",      64'(if_a.FAIL_CNT), 2);
        fault_a = 1'b0;

        // Same fault, stop-on-fail instance.
        fault_b = 1'b1;
        run(1'b1, 0, 0);
        check_val("stop_rd7_cyc",  64'(rd7_cyc), 63);
        check_val("stop_done_cyc", 64'(done_cyc), 65);
        check_val("stop_done_lat", 64'(done_cyc - rd7_cyc), 2);
        check_val("stop_busy_n",   64'(busy_n), 64);
        check_val("stop_men_n",    64'(men_n), 64);
        check_val("stop_fail",     64'(if_b.FAIL), 1);
        check_val("stop_cnt",      64'(if_b.FAIL_CNT), 1);
        check_val("stop_elem",     64'(if_b.FAIL_ELEM), 2);
        check_val("stop_addr",     64'(if_b.FAIL_ADDR), 7);
        men_after = 0;
        for (int i = 0; i < 5; i++) begin
            if (if_b.A_BIST_MEN) men_after++;
            @(negedge clk);
        end
        check_val("stop_no_more_men", 64'(men_after), 0);
        check_val("stop_done_hold",   64'(if_b.DONE), 1);
        fault_b = 1'b0;

        // Restart after a failing run; extra START at cycle 50 is ignored.
        run(1'b0, 50, 0);
        check_val("restart_fail_clr", 64'(fail_at1), 0);
        check_val("restart_cnt_clr",  64'(cnt_at1), 0);
        check_val("restart_done_cyc", 64'(done_cyc), 162);
        check_val("restart_busy_n",   64'(busy_n), 161);
        check_val("restart_fail",     64'(if_a.FAIL), 0);

        // Reset at cycle 70 of a faulty run aborts it.
        fault_a = 1'b1;
        run(1'b0, 0, 70);
        check_val("abort_busy", 64'(if_a.BUSY), 0);
        check_val("abort_done", 64'(if_a.DONE), 0);
        check_val("abort_en",   64'(if_a.A_BIST_EN), 0);
        check_val("abort_men",  64'(if_a.A_BIST_MEN), 0);
        check_val("abort_fail", 64'(if_a.FAIL), 0);
        fault_a = 1'b0;
        run(1'b0, 0, 0);
        check_val("post_abort_done_cyc", 64'(done_cyc), 162);
        check_val("post_abort_fail",     64'(if_a.FAIL), 0);
        check_val("post_abort_cnt",      64'(if_a.FAIL_CNT), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
